// File: rtl/calc_pkg.sv
// Shared types for the calculator's bitwise datapath: opcodes, issuer states, widths.
package calc_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 32;

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpXor = 3'b010,
        OpNot = 3'b011,
        OpShl = 3'b100,
        OpShr = 3'b101,
        OpAbs = 3'b110,
        OpInv = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StGotA,
        StIssue,
        StCapture,
        StHold
    } state_e;

    function automatic logic is_unary(op_e op);
        return (op == OpNot) || (op == OpAbs);
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge strobe for a synchronised button level; the edge register runs every cycle.
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic strobe
);

    logic key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign strobe = key & ~key_q;

endmodule

// File: rtl/bitwise_op_issuer.sv
// Collects A, opcode and B from switch strobes, drives bitwise_unit, waits LAT cycles,
// captures the result and offers it to the display on a valid/ready handshake.
module bitwise_op_issuer
    import calc_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned RW        = 32,
    parameter int unsigned LAT       = 1,
    parameter int unsigned SHAMT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sw_in,
    input  logic [2:0]    op_in,
    input  logic          key_load,
    input  logic          key_clear,
    output logic [2:0]    bu_op_sel,
    output logic [DW-1:0] bu_a,
    output logic [DW-1:0] bu_b,
    input  logic [RW-1:0] bu_result,
    output logic [RW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          err_shamt,
    output logic          err_op
);

    localparam logic [2:0]    LatLast  = 3'(LAT - 1);
    localparam logic [DW-1:0] ShamtMax = DW'(SHAMT_MAX);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    op_e           op_q, op_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [RW-1:0] res_q, res_d;
    logic          valid_q, valid_d;
    logic          err_shamt_q, err_shamt_d;
    logic          err_op_q, err_op_d;
    logic          strobe;
    op_e           op_new;
    logic          shamt_bad;

    key_edge_detect u_key_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (key_load),
        .strobe (strobe)
    );

    assign op_new = op_e'(op_in);
    // Shift amount is signed: negative or above the limit is rejected.
    assign shamt_bad = ((op_q == OpShl) || (op_q == OpShr)) &&
                       (sw_in[DW-1] || (sw_in > ShamtMax));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        valid_d     = valid_q;
        err_shamt_d = 1'b0;
        err_op_d    = 1'b0;

        if (key_clear) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (strobe) begin
                        a_d  = sw_in;
                        op_d = op_new;
                        if (op_new == OpInv) begin
                            err_op_d = 1'b1;
                        end else if (is_unary(op_new)) begin
                            b_d     = '0;
                            cnt_d   = '0;
                            state_d = StIssue;
                        end else begin
                            state_d = StGotA;
                        end
                    end
                end
                StGotA: begin
                    if (strobe) begin
                        if (shamt_bad) begin
                            err_shamt_d = 1'b1;
                        end else begin
                            b_d     = sw_in;
                            cnt_d   = '0;
                            state_d = StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (cnt_q == LatLast) begin
                        state_d = StCapture;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StCapture: begin
                    res_d   = bu_result;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
                StHold: begin
                    if (valid_q && res_ready) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OpAnd;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            valid_q     <= 1'b0;
            err_shamt_q <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            valid_q     <= valid_d;
            err_shamt_q <= err_shamt_d;
            err_op_q    <= err_op_d;
        end
    end

    assign bu_op_sel = op_q;
    assign bu_a      = a_q;
    assign bu_b      = b_q;
    assign res_data  = res_q;
    assign res_valid = valid_q;
    assign err_shamt = err_shamt_q;
    assign err_op    = err_op_q;
    assign busy      = (state_q == StIssue) || (state_q == StCapture) || (state_q == StHold);

endmodule
